// File: rtl/downcount_timer.sv
// downcount_timer: loadable down counter / timer.
// A loaded value counts down to zero on enabled cycles. One-shot mode parks
// at zero and raises a sticky done flag. Periodic mode reloads the captured
// value so a registered terminal-count pulse repeats every 'reload' enabled
// cycles. Every output comes straight from a register, so no input has a
// combinational path to an output.
module downcount_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             en,
  input  logic             mode,
  input  logic             stop,
  output logic [WIDTH-1:0] c,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] count, count_next;
  logic [WIDTH-1:0] reload, reload_next;
  logic             mode_q, mode_next;
  logic             tc_q, tc_next;
  logic             done_q, done_next;

  // State and datapath registers; reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= ZERO;
      reload <= ZERO;
      mode_q <= 1'b0;
      tc_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      reload <= reload_next;
      mode_q <= mode_next;
      tc_q   <= tc_next;
      done_q <= done_next;
    end
  end

  // Next-state logic with priority load > stop > count. The decrement is only
  // taken when count >= 2, and count == 1 is the expiry point, so the counter
  // can never underflow or wrap. tc defaults low, which makes it a one-cycle
  // pulse unless another expiry follows immediately (periodic, reload == 1).
  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload;
    mode_next   = mode_q;
    tc_next     = 1'b0;
    done_next   = done_q;

    if (load) begin
      count_next  = in;
      reload_next = in;
      mode_next   = mode;
      done_next   = 1'b0;
      state_next  = (in != ZERO) ? RUN : IDLE;
    end else if (stop) begin
      state_next = IDLE;
    end else if (state == RUN && en) begin
      if (count > ONE) begin
        count_next = count - ONE;
      end else if (count == ONE) begin
        tc_next = 1'b1;
        if (mode_q) begin
          count_next = reload;
        end else begin
          count_next = ZERO;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end else begin
        // A zero count while running is unreachable (load of 0 goes to IDLE);
        // fall back to IDLE rather than wrapping.
        state_next = IDLE;
      end
    end
  end

  // Outputs are driven directly from registers.
  always_comb begin
    c    = count;
    tc   = tc_q;
    busy = (state == RUN);
    done = done_q;
  end

endmodule

// File: tb/tb_downcount_timer.sv
// Directed testbench for downcount_timer with a queue-based scoreboard.
module tb_downcount_timer;

  logic       clk;
  logic       rst;
  logic [3:0] in;
  logic       load;
  logic       en;
  logic       mode;
  logic       stop;
  logic [3:0] c;
  logic       tc;
  logic       busy;
  logic       done;

  typedef struct {
    string      tag;
    logic [3:0] c;
    logic       tc;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  downcount_timer #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .in   (in),
    .load (load),
    .en   (en),
    .mode (mode),
    .stop (stop),
    .c    (c),
    .tc   (tc),
    .busy (busy),
    .done (done)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_stimulus(input logic l, input logic [3:0] v, input logic m,
                                input logic e, input logic s);
    load = l;
    in   = v;
    mode = m;
    en   = e;
    stop = s;
  endtask

  task automatic expect_state(input string tag, input logic [3:0] ec, input logic etc,
                              input logic ebusy, input logic edone);
    exp_t e;
    e.tag  = tag;
    e.c    = ec;
    e.tc   = etc;
    e.busy = ebusy;
    e.done = edone;
    sb.push_back(e);
  endtask

  task automatic check_output();
    exp_t e;
    compared++;
    assert (sb.size() != 0) else begin
      mismatched++;
      $error("[TB] FAIL scoreboard_empty observed=0 entries expected=1 entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      compared++;
      assert (c === e.c) else begin
        mismatched++;
        $error("[TB] FAIL %s.c observed=%0d expected=%0d", e.tag, c, e.c);
      end
      compared++;
      assert (tc === e.tc) else begin
        mismatched++;
        $error("[TB] FAIL %s.tc observed=%b expected=%b", e.tag, tc, e.tc);
      end
      compared++;
      assert (busy === e.busy) else begin
        mismatched++;
        $error("[TB] FAIL %s.busy observed=%b expected=%b", e.tag, busy, e.busy);
      end
      compared++;
      assert (done === e.done) else begin
        mismatched++;
        $error("[TB] FAIL %s.done observed=%b expected=%b", e.tag, done, e.done);
      end
    end
  endtask

  // Advance one rising edge and check the next scoreboard entry 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
    check_output();
  endtask

  initial begin
    // Reset held with a pending load of 4'hF.
    rst = 1'b0;
    apply_stimulus(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
    #2;
    expect_state("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    check_output();
    #8;
    rst = 1'b1;
    apply_stimulus(1'b0, 4'hF, 1'b0, 1'b1, 1'b0);
    expect_state("idle_en", 4'd0, 1'b0, 1'b0, 1'b0);
    step();

    // One-shot count of 3.
    apply_stimulus(1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
    expect_state("os_load", 4'd3, 1'b0, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    expect_state("os_2", 4'd2, 1'b0, 1'b1, 1'b0);
    step();
    expect_state("os_1", 4'd1, 1'b0, 1'b1, 1'b0);
    step();
    expect_state("os_0", 4'd0, 1'b1, 1'b0, 1'b1);
    step();
    expect_state("os_hold_a", 4'd0, 1'b0, 1'b0, 1'b1);
    step();
    expect_state("os_hold_b", 4'd0, 1'b0, 1'b0, 1'b1);
    step();

    // Periodic count of 3 for 10 cycles.
    apply_stimulus(1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
    expect_state("per_load", 4'd3, 1'b0, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      case (i % 3)
        0: expect_state("per_2", 4'd2, 1'b0, 1'b1, 1'b0);
        1: expect_state("per_1", 4'd1, 1'b0, 1'b1, 1'b0);
        default: expect_state("per_reload", 4'd3, 1'b1, 1'b1, 1'b0);
      endcase
      step();
    end

    // Enable gating, one-shot 4.
    apply_stimulus(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    expect_state("gate_load", 4'd4, 1'b0, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    expect_state("gate_3", 4'd3, 1'b0, 1'b1, 1'b0);
    step();
    en = 1'b0;
    expect_state("gate_hold_a", 4'd3, 1'b0, 1'b1, 1'b0);
    step();
    expect_state("gate_hold_b", 4'd3, 1'b0, 1'b1, 1'b0);
    step();
    en = 1'b1;
    expect_state("gate_2", 4'd2, 1'b0, 1'b1, 1'b0);
    step();
    expect_state("gate_1", 4'd1, 1'b0, 1'b1, 1'b0);
    step();
    expect_state("gate_0", 4'd0, 1'b1, 1'b0, 1'b1);
    step();

    // Priority and abort: run 9 down to 5, then stop.
    apply_stimulus(1'b1, 4'd9, 1'b0, 1'b1, 1'b0);
    expect_state("pri_load", 4'd9, 1'b0, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int v = 8; v >= 5; v--) begin
      expect_state("pri_run", 4'(v), 1'b0, 1'b1, 1'b0);
      step();
    end
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    expect_state("pri_stop", 4'd5, 1'b0, 1'b0, 1'b0);
    step();
    expect_state("pri_stopped", 4'd5, 1'b0, 1'b0, 1'b0);
    step();
    apply_stimulus(1'b1, 4'd2, 1'b0, 1'b1, 1'b1);
    expect_state("pri_load_wins", 4'd2, 1'b0, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
    expect_state("pri_load0", 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    expect_state("pri_idle", 4'd0, 1'b0, 1'b0, 1'b0);
    step();

    // Mode toggled mid-count is ignored: stays one-shot.
    apply_stimulus(1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
    expect_state("mode_load", 4'd2, 1'b0, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    expect_state("mode_1", 4'd1, 1'b0, 1'b1, 1'b0);
    step();
    expect_state("mode_0", 4'd0, 1'b1, 1'b0, 1'b1);
    step();

    // Periodic reload of 1: tc every cycle.
    apply_stimulus(1'b1, 4'd1, 1'b1, 1'b1, 1'b0);
    expect_state("p1_load", 4'd1, 1'b0, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      expect_state("p1_tick", 4'd1, 1'b1, 1'b1, 1'b0);
      step();
    end

    // Maximum one-shot load: 15 enabled cycles to tc.
    apply_stimulus(1'b1, 4'hF, 1'b0, 1'b1, 1'b0);
    expect_state("max_load", 4'd15, 1'b0, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int v = 14; v >= 1; v--) begin
      expect_state("max_run", 4'(v), 1'b0, 1'b1, 1'b0);
      step();
    end
    expect_state("max_tc", 4'd0, 1'b1, 1'b0, 1'b1);
    step();

    // Asynchronous reset mid-count at c=7.
    apply_stimulus(1'b1, 4'd9, 1'b0, 1'b1, 1'b0);
    expect_state("ar_load", 4'd9, 1'b0, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    expect_state("ar_8", 4'd8, 1'b0, 1'b1, 1'b0);
    step();
    expect_state("ar_7", 4'd7, 1'b0, 1'b1, 1'b0);
    step();
    #2;
    rst = 1'b0;
    #1;
    expect_state("ar_async", 4'd0, 1'b0, 1'b0, 1'b0);
    check_output();
    expect_state("ar_held", 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    expect_state("ar_release", 4'd0, 1'b0, 1'b0, 1'b0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
